// File: rtl/instr_fetch.sv
// Instruction fetch unit: a small register-file program memory plus a
// fetch/hold/halt sequencer that presents one instruction at a time to the
// consumer through a registered instruction/valid handshake.
module instr_fetch #(
  parameter int INSTR_WIDTH = 20,
  parameter int ADDR_BITS   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   next,
  input  logic                   prog_we,
  input  logic [ADDR_BITS-1:0]   prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [ADDR_BITS-1:0]   pc,
  output logic                   done
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0]   PC_ZERO   = '0;
  localparam logic [ADDR_BITS-1:0]   PC_ONE    = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0]   PC_LAST   = '1;
  localparam logic [INSTR_WIDTH-1:0] INSTR_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;

  // Program memory has no reset: contents persist across rst and are
  // undefined until the loader writes them.
  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
  logic                   mem_we_s;
  logic [INSTR_WIDTH-1:0] fetch_word_s;
  logic                   fetch_is_halt_s;

  // A word whose two top bits are zero marks the end of the program.
  function automatic logic is_halt_word(input logic [INSTR_WIDTH-1:0] word);
    return (word[INSTR_WIDTH-1 -: 2] == 2'b00);
  endfunction

  // Loader writes are accepted only while the sequencer is parked, and never
  // on an edge where reset is held.
  always_comb begin
    mem_we_s = 1'b0;
    if (prog_we && !rst && ((state_q == ST_IDLE) || (state_q == ST_HALT))) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Synchronous write port of the program memory.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // Read port feeds only the instruction register.
  always_comb begin
    fetch_word_s    = mem_q[pc_q];
    fetch_is_halt_s = is_halt_word(fetch_word_s);
  end

  // Next-state and next-output logic of the fetch sequencer.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    done_d  = done_q;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        done_d  = 1'b0;
        pc_d    = PC_ZERO;
        if (start) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (fetch_is_halt_s) begin
          instr_d = INSTR_ZERO;
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = ST_HALT;
        end else begin
          instr_d = fetch_word_s;
          valid_d = 1'b1;
          done_d  = 1'b0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (next) begin
          valid_d = 1'b0;
          if (pc_q == PC_LAST) begin
            // Last address consumed: stop rather than wrap to 0.
            done_d  = 1'b1;
            instr_d = INSTR_ZERO;
            state_d = ST_HALT;
          end else begin
            pc_d    = pc_q + PC_ONE;
            state_d = ST_FETCH;
          end
        end else begin
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HALT: begin
        valid_d = 1'b0;
        instr_d = INSTR_ZERO;
        if (start) begin
          pc_d    = PC_ZERO;
          done_d  = 1'b0;
          state_d = ST_FETCH;
        end else begin
          done_d  = 1'b1;
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = PC_ZERO;
        instr_d = INSTR_ZERO;
        valid_d = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= PC_ZERO;
      instr_q <= INSTR_ZERO;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign done        = done_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter INSTR_WIDTH, default 20, instruction word width in bits.
REQ-002 Parameter ADDR_BITS, default 5, program-memory address width (32 words).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begin (or restart) fetching at address 0.
REQ-006 next  input  1  consumer has taken the current instruction; advance.
REQ-007 prog_we  input  1  program-memory write enable.
REQ-008 prog_addr  input  ADDR_BITS  program-memory write address.
REQ-009 prog_data  input  INSTR_WIDTH  program-memory write data.
REQ-010 instruction  output  INSTR_WIDTH  registered instruction, drives the CPU instruction input.
REQ-011 instr_valid  output  1  instruction holds a fetched, not-yet-consumed word.
REQ-012 pc  output  ADDR_BITS  address of the word in, or being loaded into, instruction.
REQ-013 done  output  1  fetch halted.

Function
REQ-014 Program memory: 2**ADDR_BITS x INSTR_WIDTH registers; synchronous write; read into instruction register only.
REQ-015 FSM states: IDLE, FETCH, HOLD, HALT; any other encoding returns to IDLE on the next edge.
REQ-016 IDLE: valid=0, done=0, pc=0; prog_we=1 writes prog_data to mem[prog_addr]; start=1 -> FETCH.
REQ-017 FETCH (exactly one cycle): instruction <= mem[pc]; if mem[pc][19:18] != 2'b00 -> HOLD with valid=1 on the same edge.
REQ-018 FETCH with mem[pc][19:18] == 2'b00 (halt word): instruction <= 0, valid=0, done=1 -> HALT.
REQ-019 In FETCH, instruction keeps its previous value until the FETCH edge; valid=0 throughout.
REQ-020 HOLD: instruction and pc stable, valid=1, until next=1.
REQ-021 HOLD, next=1, pc < 2**ADDR_BITS-1: pc <= pc+1, valid <= 0 -> FETCH.
REQ-022 HOLD, next=1, pc == 2**ADDR_BITS-1: no wrap; valid <= 0, done <= 1, instruction <= 0 -> HALT; pc unchanged.
REQ-023 Latency: start to valid = 2 edges; next to following valid = 2 edges.
REQ-024 HALT: done=1, valid=0, instruction=0; prog_we writes accepted; start=1 -> pc <= 0, done <= 0 -> FETCH.
REQ-025 prog_we is ignored in FETCH and HOLD.
REQ-026 start is ignored in FETCH and HOLD.
REQ-027 next is ignored in IDLE, FETCH and HALT.
REQ-028 Simultaneous prog_we and start in IDLE or HALT: write completes on that edge; the subsequent FETCH reads the updated contents.
REQ-029 pc never exceeds 2**ADDR_BITS-1; increment arithmetic is ADDR_BITS wide.

Reset
REQ-030 rst=1 forces, without waiting for clk: state=IDLE, pc=0, instruction=0, instr_valid=0, done=0.
REQ-031 Reset in any state, including mid-FETCH or HOLD, aborts the operation; no write or pc update occurs on an edge where rst=1.
REQ-032 Program-memory contents are not cleared by reset; they are undefined until written.
REQ-033 Operation resumes only via start after rst deasserts.

Verification
REQ-034 Load mem[0]=20'h4_1230, mem[1]=20'h8_0050, mem[2]=20'h0_0000; pulse start -> 2 edges later instruction=20'h41230, valid=1, pc=0.
REQ-035 Same program, pulse next each time valid=1 -> instruction 20'h80050 at pc=1; after the next pulse, done=1, valid=0, instruction=0, pc=2.
REQ-036 Fill all 32 words with 20'h40000|index and consume all words -> after pc=31 is consumed, done=1, pc=31, no wrap to 0.
REQ-037 Hold next=0 for 10 cycles in HOLD -> instruction, pc and valid unchanged; prog_we pulse to mem[pc] in HOLD -> contents not changed (verified after restart).
REQ-038 Assert rst asynchronously mid-HOLD at pc=3 -> outputs zero immediately; start after release -> fetch resumes from pc=0.
REQ-039 In HALT, prog_we and start on the same edge rewriting mem[0]=20'hC_0010 -> 2 edges later instruction=20'hC0010, valid=1.
